psum_drain_row: RTL and testbench
=================================

PSUM_DRAIN_ROW -- requirements
Module: psum_drain_row

Interface
REQ-001 SHALL have parameter psum_bw, default 20: per-lane partial-sum width, two's complement.
REQ-002 SHALL have parameter M, default 4: number of lanes in the upstream DP row.
REQ-003 SHALL have parameter acc_bw, default 24: per-lane accumulator width, two's complement, with acc_bw >= psum_bw.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port capture, input, 1 bit: psum_in is valid this cycle.
REQ-007 SHALL have port last_tile, input, 1 bit: qualifies capture as the final tile of the current output group.
REQ-008 SHALL have port psum_in, input, M*psum_bw bits: lane i occupies [(i+1)*psum_bw-1 -: psum_bw].
REQ-009 SHALL have port relu_en, input, 1 bit: applies ReLU on drained data.
REQ-010 SHALL have port clear_err, input, 1 bit: clears the sticky flags.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the current beat.
REQ-012 SHALL have port out_valid, output, 1 bit: out_data and out_lane are valid.
REQ-013 SHALL have port out_data, output, acc_bw bits: the drained accumulator value.
REQ-014 SHALL have port out_lane, output, $clog2(M) bits: lane index of out_data.
REQ-015 SHALL have port busy, output, 1 bit: high while in the DRAIN state.
REQ-016 SHALL have port sat_err, output, 1 bit: sticky; set when any accumulation saturates.
REQ-017 SHALL have port drop_err, output, 1 bit: sticky; set when a capture is ignored.

Function
REQ-018 SHALL implement a two-state FSM, ACCUM and DRAIN, that resets to ACCUM.
REQ-019 In ACCUM, capture SHALL update acc[i] <= sat(acc[i] + sext(psum_in lane i)) for every lane in the same edge.
REQ-020 Saturation SHALL clamp to +(2^(acc_bw-1)-1) or -2^(acc_bw-1) and SHALL set sat_err.
REQ-021 In ACCUM, capture with last_tile SHALL accumulate and then enter DRAIN on the same edge, so out_valid is high exactly one cycle after the capture.
REQ-022 last_tile without capture SHALL be ignored.
REQ-023 In DRAIN, out_valid SHALL be 1; out_lane SHALL start at 0.
REQ-024 In DRAIN, out_data SHALL equal acc[out_lane], or 0 if relu_en is high and acc[out_lane] is negative.
REQ-025 In DRAIN, out_lane and out_data SHALL hold stable while out_ready is low.
REQ-026 out_valid && out_ready SHALL advance out_lane by 1.
REQ-027 Acceptance at lane M-1 SHALL zero all accumulators, reset out_lane to 0, and return the FSM to ACCUM; out_valid SHALL be 0 the next cycle.
REQ-028 capture while in DRAIN SHALL be discarded, SHALL leave the accumulators unchanged, and SHALL set drop_err.
REQ-029 clear_err SHALL zero sat_err and drop_err; a set condition in the same cycle SHALL take priority over the clear.
REQ-030 relu_en SHALL be sampled combinationally per beat; it has no effect on the stored accumulator values.

Reset
REQ-031 Asserting reset (low) SHALL immediately force the FSM to ACCUM, all accumulators to 0, out_lane to 0, and out_valid, busy, sat_err and drop_err to 0, including in the middle of a drain.
REQ-032 After reset deasserts, the first capture SHALL be accepted on the next rising edge.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (ACCUM, DRAIN) and the saturating-add width constants.
REQ-034 One sub-module SHALL be used: sat_acc, a single-lane signed saturating adder, instantiated M times in a generate loop.
REQ-035 Accumulators SHALL be flopped; out_data SHALL be a registered-state mux with no combinational path from out_ready to out_data.

Verification
REQ-036 Three captures of lane psums {1,2,3,4}, the last with last_tile, then out_ready held at 1 -> beats lane 0..3 = 3, 6, 9, 12 on consecutive cycles; busy is high for 4 cycles.
REQ-037 psum_bw=20, acc_bw=24, and 20 captures of 0x7FFFF on lane 0 -> out_data = 0x7FFFFF and sat_err = 1; clear_err then drives sat_err to 0.
REQ-038 relu_en=1 with lane psums {-5,7,-1,0} and last_tile -> beats 0, 7, 0, 0; with relu_en=0 -> beats -5, 7, -1, 0.
REQ-039 out_ready toggling 1,0,0,1 during a drain -> out_lane and out_data held across the stall cycles; no lane is skipped or duplicated.
REQ-040 capture pulsed at lane 1 of a drain -> drop_err = 1, the drained values are unchanged, and after the drain the accumulators start from 0.
REQ-041 reset asserted with out_lane = 2 mid-drain -> out_valid = 0 immediately; a new group after reset drains only new data.

Source files
------------

// File: rtl/psum_drain_row_pkg.sv
// rtl/psum_drain_row_pkg.sv - shared types and constants for the psum drain row
// Purpose : FSM state encoding and saturating-add width constants.
// Ports   : none (package).
package psum_drain_row_pkg;

  // ACCUM: captures fold into the accumulators; DRAIN: lanes stream out.
  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  // One guard bit above acc_bw is enough to see any signed overflow of a
  // single two's-complement add (the two top bits of the sum disagree).
  localparam int unsigned SAT_GUARD = 1;

endpackage

// File: rtl/sat_acc.sv
// rtl/sat_acc.sv - single-lane signed saturating adder
// Purpose : sum = clamp(acc + sext(psum)) to the signed acc_bw range.
// Ports   : acc  - current accumulator value (acc_bw, signed)
//           psum - incoming partial sum (psum_bw, signed)
//           sum  - saturated result (acc_bw, signed)
//           sat  - high when the result was clamped
module sat_acc
  import psum_drain_row_pkg::*;
#(
  parameter int psum_bw = 20,
  parameter int acc_bw  = 24
) (
  input  logic [acc_bw-1:0]  acc,
  input  logic [psum_bw-1:0] psum,
  output logic [acc_bw-1:0]  sum,
  output logic               sat
);

  localparam int W = acc_bw + SAT_GUARD;
  localparam logic [acc_bw-1:0] ACC_MAX = {1'b0, {(acc_bw-1){1'b1}}};
  localparam logic [acc_bw-1:0] ACC_MIN = {1'b1, {(acc_bw-1){1'b0}}};

  logic [W-1:0] acc_x;
  logic [W-1:0] psum_x;
  logic [W-1:0] wide;

  always_comb begin
    acc_x  = {{SAT_GUARD{acc[acc_bw-1]}}, acc};
    psum_x = {{(W-psum_bw){psum[psum_bw-1]}}, psum};
    wide   = acc_x + psum_x;
    // Guard bit differing from the acc_bw sign bit means overflow; the guard
    // bit carries the true sign and picks which rail to clamp to.
    sat    = wide[W-1] ^ wide[acc_bw-1];
    if (sat) begin
      sum = wide[W-1] ? ACC_MIN : ACC_MAX;
    end else begin
      sum = wide[acc_bw-1:0];
    end
  end

endmodule

// File: rtl/psum_drain_row.sv
// rtl/psum_drain_row.sv - per-lane psum accumulator row with serial drain
// Purpose : accumulate M lanes of partial sums per output group, then stream
//           the accumulators out one lane per accepted beat.
// Ports   : clk, reset (async, active-low)
//           capture, last_tile, psum_in[M*psum_bw] - psum input side
//           relu_en   - zero negative values on the output beat
//           clear_err - clears sat_err / drop_err
//           out_ready, out_valid, out_data[acc_bw], out_lane - drain stream
//           busy      - high while draining
//           sat_err, drop_err - sticky error flags
module psum_drain_row
  import psum_drain_row_pkg::*;
#(
  parameter int psum_bw = 20,
  parameter int M       = 4,
  parameter int acc_bw  = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   capture,
  input  logic                   last_tile,
  input  logic [M*psum_bw-1:0]   psum_in,
  input  logic                   relu_en,
  input  logic                   clear_err,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [acc_bw-1:0]      out_data,
  output logic [$clog2(M)-1:0]   out_lane,
  output logic                   busy,
  output logic                   sat_err,
  output logic                   drop_err
);

  localparam int LW = $clog2(M);
  localparam logic [LW-1:0] LAST_LANE = LW'(M - 1);

  drain_state_t state_q, state_d;

  logic [acc_bw-1:0] acc_q [M];
  logic [acc_bw-1:0] sum   [M];
  logic [M-1:0]      sat_lane;
  logic [LW-1:0]     lane_q;
  logic              sat_err_q;
  logic              drop_err_q;

  logic take;
  logic drop;
  logic beat;
  logic last_beat;
  logic [acc_bw-1:0] sel;

  for (genvar g = 0; g < M; g++) begin : g_lane
    sat_acc #(
      .psum_bw(psum_bw),
      .acc_bw (acc_bw)
    ) u_sat_acc (
      .acc (acc_q[g]),
      .psum(psum_in[(g+1)*psum_bw-1 -: psum_bw]),
      .sum (sum[g]),
      .sat (sat_lane[g])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    out_valid = 1'b0;
    busy      = 1'b0;
    take      = 1'b0;
    drop      = 1'b0;
    beat      = 1'b0;
    last_beat = 1'b0;
    case (state_q)
      ACCUM: begin
        if (capture) begin
          take = 1'b1;
          if (last_tile) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        drop      = capture;
        if (out_ready) begin
          beat = 1'b1;
          if (lane_q == LAST_LANE) begin
            last_beat = 1'b1;
            state_d   = ACCUM;
          end
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < M; i++) acc_q[i] <= '0;
      lane_q     <= '0;
      sat_err_q  <= 1'b0;
      drop_err_q <= 1'b0;
    end else begin
      if (last_beat) begin
        for (int i = 0; i < M; i++) acc_q[i] <= '0;
        lane_q <= '0;
      end else begin
        if (take) begin
          for (int i = 0; i < M; i++) acc_q[i] <= sum[i];
        end
        if (beat) begin
          lane_q <= lane_q + 1'b1;
        end
      end
      // A new error event in the same cycle wins over clear_err.
      sat_err_q  <= (take & (|sat_lane)) | (sat_err_q & ~clear_err);
      drop_err_q <= drop | (drop_err_q & ~clear_err);
    end
  end

  // Output mux reads only flopped state; out_ready never reaches out_data.
  always_comb begin
    sel      = acc_q[lane_q];
    out_data = (relu_en && sel[acc_bw-1]) ? '0 : sel;
  end

  assign out_lane = lane_q;
  assign sat_err  = sat_err_q;
  assign drop_err = drop_err_q;

endmodule

// File: tb/tb_psum_drain_row.sv
// tb/tb_psum_drain_row.sv - directed self-checking bench for psum_drain_row
module tb_psum_drain_row;

  localparam int PSUM_BW = 20;
  localparam int M       = 4;
  localparam int ACC_BW  = 24;

  logic                   clk;
  logic                   reset;
  logic                   capture;
  logic                   last_tile;
  logic [M*PSUM_BW-1:0]   psum_in;
  logic                   relu_en;
  logic                   clear_err;
  logic                   out_ready;
  logic                   out_valid;
  logic [ACC_BW-1:0]      out_data;
  logic [$clog2(M)-1:0]   out_lane;
  logic                   busy;
  logic                   sat_err;
  logic                   drop_err;

  int n_checks = 0;
  int n_pass   = 0;

  psum_drain_row #(
    .psum_bw(PSUM_BW),
    .M      (M),
    .acc_bw (ACC_BW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .last_tile(last_tile),
    .psum_in  (psum_in),
    .relu_en  (relu_en),
    .clear_err(clear_err),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_lane (out_lane),
    .busy     (busy),
    .sat_err  (sat_err),
    .drop_err (drop_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [M*PSUM_BW-1:0] pack(input int a, input int b, input int c, input int d);
    return {PSUM_BW'(d), PSUM_BW'(c), PSUM_BW'(b), PSUM_BW'(a)};
  endfunction

  function automatic logic [31:0] d24(input int v);
    return {8'b0, ACC_BW'(v)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cap(input logic [M*PSUM_BW-1:0] p, input logic last);
    capture   = 1'b1;
    last_tile = last;
    psum_in   = p;
    tick();
    capture   = 1'b0;
    last_tile = 1'b0;
    psum_in   = '0;
  endtask

  task automatic beat_check(input string tag, input int lane, input int val);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_lane"}, {30'b0, out_lane}, lane);
    check({tag, "_data"}, {8'b0, out_data}, d24(val));
  endtask

  initial begin
    int exp_lane;
    int vals[4];
    logic rdy_pat[6];

    reset = 1'b0; capture = 1'b0; last_tile = 1'b0; psum_in = '0;
    relu_en = 1'b0; clear_err = 1'b0; out_ready = 1'b0;
    #12;
    check("rst_valid", {31'b0, out_valid}, 0);
    check("rst_busy", {31'b0, busy}, 0);
    check("rst_lane", {30'b0, out_lane}, 0);
    check("rst_sat", {31'b0, sat_err}, 0);
    check("rst_drop", {31'b0, drop_err}, 0);
    reset = 1'b1;
    #2;

    // last_tile alone is ignored
    last_tile = 1'b1;
    tick();
    last_tile = 1'b0;
    check("lt_only_valid", {31'b0, out_valid}, 0);

    // three captures of {1,2,3,4}, ready held high
    out_ready = 1'b1;
    cap(pack(1, 2, 3, 4), 1'b0);
    cap(pack(1, 2, 3, 4), 1'b0);
    check("acc_no_valid", {31'b0, out_valid}, 0);
    cap(pack(1, 2, 3, 4), 1'b1);
    for (int k = 0; k < 4; k++) begin
      beat_check($sformatf("sum3_b%0d", k), k, 3 * (k + 1));
      check($sformatf("sum3_busy%0d", k), {31'b0, busy}, 1);
      tick();
    end
    check("sum3_end_valid", {31'b0, out_valid}, 0);
    check("sum3_end_busy", {31'b0, busy}, 0);

    // relu on/off per beat, stepping one lane at a time
    out_ready = 1'b0;
    vals = '{-5, 7, -1, 0};
    cap(pack(-5, 7, -1, 0), 1'b1);
    for (int k = 0; k < 4; k++) begin
      relu_en = 1'b1;
      #1;
      beat_check($sformatf("relu1_b%0d", k), k, (vals[k] < 0) ? 0 : vals[k]);
      relu_en = 1'b0;
      #1;
      beat_check($sformatf("relu0_b%0d", k), k, vals[k]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
    check("relu_end_valid", {31'b0, out_valid}, 0);

    // stall pattern 1,0,0,1,1,1
    vals = '{10, 20, 30, 40};
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    cap(pack(10, 20, 30, 40), 1'b1);
    exp_lane = 0;
    for (int k = 0; k < 6; k++) begin
      out_ready = rdy_pat[k];
      beat_check($sformatf("stall_c%0d", k), exp_lane, vals[exp_lane]);
      tick();
      if (rdy_pat[k]) exp_lane++;
    end
    check("stall_end_valid", {31'b0, out_valid}, 0);

    // capture during drain is dropped
    out_ready = 1'b1;
    cap(pack(1, 2, 3, 4), 1'b1);
    tick();
    out_ready = 1'b0;
    check("drop_pre", {31'b0, drop_err}, 0);
    cap(pack(100, 100, 100, 100), 1'b0);
    check("drop_flag", {31'b0, drop_err}, 1);
    beat_check("drop_b1", 1, 2);
    out_ready = 1'b1;
    beat_check("drop_b1r", 1, 2);
    tick();
    beat_check("drop_b2", 2, 3);
    tick();
    beat_check("drop_b3", 3, 4);
    tick();
    cap(pack(1, 1, 1, 1), 1'b1);
    for (int k = 0; k < 4; k++) begin
      beat_check($sformatf("fresh_b%0d", k), k, 1);
      tick();
    end
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("drop_cleared", {31'b0, drop_err}, 0);

    // positive saturation on lane 0
    out_ready = 1'b0;
    for (int k = 0; k < 20; k++) cap(pack(32'h7FFFF, 0, 0, 0), (k == 19));
    check("sat_flag", {31'b0, sat_err}, 1);
    beat_check("sat_b0", 0, 32'h7FFFFF);
    out_ready = 1'b1;
    repeat (4) tick();
    check("sat_end_valid", {31'b0, out_valid}, 0);
    check("sat_sticky", {31'b0, sat_err}, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    check("sat_cleared", {31'b0, sat_err}, 0);

    // negative saturation clamps to the minimum
    out_ready = 1'b0;
    for (int k = 0; k < 17; k++) cap(pack(-524288, 0, 0, 0), (k == 16));
    beat_check("nsat_b0", 0, 32'h800000);
    check("nsat_flag", {31'b0, sat_err}, 1);
    out_ready = 1'b1;
    repeat (4) tick();
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;

    // reset mid-drain at lane 2
    out_ready = 1'b1;
    cap(pack(5, 6, 7, 8), 1'b1);
    tick();
    tick();
    out_ready = 1'b0;
    beat_check("mid_b2", 2, 7);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_valid", {31'b0, out_valid}, 0);
    check("mid_rst_busy", {31'b0, busy}, 0);
    check("mid_rst_lane", {30'b0, out_lane}, 0);
    #1;
    reset = 1'b1;
    out_ready = 1'b1;
    cap(pack(1, 2, 3, 4), 1'b1);
    for (int k = 0; k < 4; k++) begin
      beat_check($sformatf("post_rst_b%0d", k), k, k + 1);
      tick();
    end
    check("post_rst_end", {31'b0, out_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
